// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite rotation trig scheduler.
package sprite_pkg;

    localparam int TRIG_W = 18;
    localparam logic signed [TRIG_W-1:0] TRIG_ONE = 18'sh10000;

    typedef logic signed [TRIG_W-1:0] trig_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        COMMIT
    } sched_state_t;

endpackage

// File: rtl/lookup_delay_line.sv
// Tracks in-flight ROM lookups: a {valid, payload} shift register matching ROM latency.
module lookup_delay_line #(
    parameter int DEPTH = 2,
    parameter int W     = 3
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         any_valid_o
);

    logic [DEPTH-1:0] valid_q;
    logic [W-1:0]     data_q [DEPTH];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
        end else begin
            valid_q[0] <= valid_i;
            data_q[0]  <= data_i;
            for (int i = DEPTH - 1; i > 0; i--) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign valid_o     = valid_q[DEPTH-1];
    assign data_o      = data_q[DEPTH-1];
    assign any_valid_o = |valid_q;

endmodule

// File: rtl/sprite_trig_scheduler.sv
// Per-frame sin/cos lookup for all sprites through one shared ROM, with an
// atomic commit so drawers never see a half-updated rotation set.
module sprite_trig_scheduler #(
    parameter int NUM_SPRITES = 8,
    parameter int ANGLE_W     = 8,
    parameter int ROM_LATENCY = 2,
    parameter int TRIG_W      = 18
) (
    input  logic                            clk,
    input  logic                            resetN,
    input  logic                            frame_start,
    input  logic [NUM_SPRITES*ANGLE_W-1:0]  angle,
    output logic [ANGLE_W-1:0]              trig_addr,
    input  logic signed [TRIG_W-1:0]        trig_sin,
    input  logic signed [TRIG_W-1:0]        trig_cos,
    output logic [NUM_SPRITES*TRIG_W-1:0]   sin_val,
    output logic [NUM_SPRITES*TRIG_W-1:0]   cos_val,
    output logic                            busy,
    output logic                            done,
    output logic                            overrun
);
    import sprite_pkg::*;

    localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);
    localparam logic signed [TRIG_W-1:0] ONE = TRIG_W'(TRIG_ONE);

    sched_state_t              state_q;
    logic [IDX_W-1:0]          idx_q;
    logic [IDX_W-1:0]          idx_d;
    logic [ANGLE_W-1:0]        addr_q;
    logic [ANGLE_W-1:0]        snap_q    [NUM_SPRITES];
    logic signed [TRIG_W-1:0]  sh_sin_q  [NUM_SPRITES];
    logic signed [TRIG_W-1:0]  sh_cos_q  [NUM_SPRITES];
    logic signed [TRIG_W-1:0]  out_sin_q [NUM_SPRITES];
    logic signed [TRIG_W-1:0]  out_cos_q [NUM_SPRITES];
    logic                      busy_q;
    logic                      done_q;
    logic                      overrun_q;
    logic                      dl_valid;
    logic                      dl_any;
    logic [IDX_W-1:0]          dl_idx;

    assign idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);

    lookup_delay_line #(
        .DEPTH (ROM_LATENCY),
        .W     (IDX_W)
    ) u_delay (
        .clk         (clk),
        .resetN      (resetN),
        .valid_i     (state_q == ISSUE),
        .data_i      (idx_q),
        .valid_o     (dl_valid),
        .data_o      (dl_idx),
        .any_valid_o (dl_any)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            addr_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int k = 0; k < NUM_SPRITES; k++) begin
                snap_q[k]    <= '0;
                sh_sin_q[k]  <= '0;
                sh_cos_q[k]  <= ONE;
                out_sin_q[k] <= '0;
                out_cos_q[k] <= ONE;
            end
        end else begin
            done_q <= 1'b0;
            if (frame_start && busy_q) overrun_q <= 1'b1;
            if (dl_valid) begin
                sh_sin_q[dl_idx] <= trig_sin;
                sh_cos_q[dl_idx] <= trig_cos;
            end
            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        for (int k = 0; k < NUM_SPRITES; k++)
                            snap_q[k] <= angle[k*ANGLE_W +: ANGLE_W];
                        addr_q  <= angle[ANGLE_W-1:0];
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (idx_q == LAST_IDX) state_q <= DRAIN;
                    else                   addr_q  <= snap_q[idx_d];
                    idx_q <= idx_d;
                end
                DRAIN: begin
                    // Outputs are loaded on entry so they and done appear in the COMMIT cycle.
                    if (!dl_any) begin
                        for (int k = 0; k < NUM_SPRITES; k++) begin
                            out_sin_q[k] <= sh_sin_q[k];
                            out_cos_q[k] <= sh_cos_q[k];
                        end
                        done_q  <= 1'b1;
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_SPRITES; k++) begin : g_pack
        assign sin_val[k*TRIG_W +: TRIG_W] = out_sin_q[k];
        assign cos_val[k*TRIG_W +: TRIG_W] = out_cos_q[k];
    end

    assign trig_addr = addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sprite_trig_scheduler.sv
// Scoreboard bench: default 8-sprite instance plus a 1-sprite, latency-1 instance.
module tb_sprite_trig_scheduler;

    localparam int NS = 8;
    localparam int AW = 8;
    localparam int TW = 18;

    typedef struct { int cyc; logic [NS*TW-1:0] s; logic [NS*TW-1:0] c; } exp_t;
    typedef struct { int cyc; logic [AW-1:0] a; } addr_t;
    typedef struct { int cyc; logic [TW-1:0] s; logic [TW-1:0] c; } exp1_t;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    logic mon_en = 1'b0;

    logic                   frame_start = 1'b0;
    logic [NS*AW-1:0]       angle = '0;
    logic [AW-1:0]          trig_addr;
    logic signed [TW-1:0]   trig_sin, trig_cos;
    logic [NS*TW-1:0]       sin_val, cos_val;
    logic                   busy, done, overrun;

    logic                   frame_start1 = 1'b0;
    logic [AW-1:0]          angle1 = '0;
    logic [AW-1:0]          trig_addr1;
    logic signed [TW-1:0]   trig_sin1, trig_cos1;
    logic [TW-1:0]          sin_val1, cos_val1;
    logic                   busy1, done1, overrun1;

    exp_t  exp_q[$];
    addr_t addr_q[$];
    exp1_t exp1_q[$];

    localparam logic [NS*TW-1:0] ID_SIN = '0;
    localparam logic [NS*TW-1:0] ID_COS = {NS{18'h10000}};
    logic [NS*TW-1:0] cur_sin = ID_SIN, cur_cos = ID_COS;
    logic [TW-1:0]    cur_sin1 = '0, cur_cos1 = 18'h10000;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sprite_trig_scheduler dut (
        .clk(clk), .resetN(resetN), .frame_start(frame_start), .angle(angle),
        .trig_addr(trig_addr), .trig_sin(trig_sin), .trig_cos(trig_cos),
        .sin_val(sin_val), .cos_val(cos_val), .busy(busy), .done(done), .overrun(overrun)
    );

    sprite_trig_scheduler #(.NUM_SPRITES(1), .ROM_LATENCY(1)) dut1 (
        .clk(clk), .resetN(resetN), .frame_start(frame_start1), .angle(angle1),
        .trig_addr(trig_addr1), .trig_sin(trig_sin1), .trig_cos(trig_cos1),
        .sin_val(sin_val1), .cos_val(cos_val1), .busy(busy1), .done(done1), .overrun(overrun1)
    );

    // ROM model: sin = addr << 8, cos = ~sin, fixed pipeline latency
    logic [AW-1:0] ra1 = '0, ra2 = '0, rb1 = '0;
    always @(posedge clk) begin
        ra1 <= trig_addr;
        ra2 <= ra1;
        rb1 <= trig_addr1;
    end
    assign trig_sin  = 18'({ra2, 8'h00});
    assign trig_cos  = ~trig_sin;
    assign trig_sin1 = 18'({rb1, 8'h00});
    assign trig_cos1 = ~trig_sin1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NS*TW-1:0] exp_sin(input logic [NS*AW-1:0] ang);
        logic [NS*TW-1:0] r;
        r = '0;
        for (int k = 0; k < NS; k++) r[k*TW +: TW] = 18'({ang[k*AW +: AW], 8'h00});
        return r;
    endfunction

    function automatic logic [NS*AW-1:0] ramp(input int base, input int inc);
        logic [NS*AW-1:0] r;
        for (int k = 0; k < NS; k++) r[k*AW +: AW] = 8'(base + k * inc);
        return r;
    endfunction

    task automatic start_frame(input logic [NS*AW-1:0] ang);
        exp_t  e;
        addr_t a;
        angle = ang;
        frame_start = 1'b1;
        e.cyc = cyc + NS + 2 + 2;
        e.s = exp_sin(ang);
        e.c = ~e.s;
        exp_q.push_back(e);
        for (int k = 0; k < NS; k++) begin
            a.cyc = cyc + 1 + k;
            a.a = ang[k*AW +: AW];
            addr_q.push_back(a);
        end
        step();
        frame_start = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t  e;
        addr_t a;
        if (mon_en) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL spurious_done: got done=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("sin_val", sin_val, e.s);
                    chk("cos_val", cos_val, e.c);
                    cur_sin = e.s;
                    cur_cos = e.c;
                end
            end else begin
                chk("sin_stable", sin_val, cur_sin);
                chk("cos_stable", cos_val, cur_cos);
            end
            if (addr_q.size() != 0 && addr_q[0].cyc == cyc) begin
                a = addr_q.pop_front();
                chk("trig_addr", trig_addr, a.a);
            end
        end
    end

    always @(negedge clk) begin
        exp1_t e;
        if (mon_en) begin
            if (done1) begin
                if (exp1_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL spurious_done1: got done1=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = exp1_q.pop_front();
                    chk("done1_cycle", cyc, e.cyc);
                    chk("sin_val1", sin_val1, e.s);
                    chk("cos_val1", cos_val1, e.c);
                    cur_sin1 = e.s;
                    cur_cos1 = e.c;
                end
            end else begin
                chk("sin1_stable", sin_val1, cur_sin1);
                chk("cos1_stable", cos_val1, cur_cos1);
            end
        end
    end

    initial begin
        exp1_t e1;
        int c0;
        step();
        mon_en = 1'b1;
        step();
        chk("rst_sin", sin_val, ID_SIN);
        chk("rst_cos", cos_val, ID_COS);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_addr", trig_addr, 0);
        resetN = 1'b1;
        step();

        // Frame A: angles k*16
        start_frame(ramp(0, 16));
        chk("busy_first", busy, 1);
        repeat (11) step();
        chk("busy_last", busy, 1);
        step();
        chk("busy_after", busy, 0);
        chk("sprite3_sin", sin_val[3*TW +: TW], 18'h03000);
        chk("sprite3_cos", cos_val[3*TW +: TW], 18'h3CFFF);

        // Frame B: angles change in cycle 2, snapshot must hold
        start_frame(ramp(5, 16));
        step();
        angle = '1;
        repeat (11) step();

        // Frame C with wrap-around angles; second frame_start in cycle 5
        start_frame(64'h4002FE7F800100FF);
        repeat (4) step();
        frame_start = 1'b1;
        angle = ramp(1, 1);
        step();
        frame_start = 1'b0;
        chk("overrun_set", overrun, 1);
        chk("busy_overrun", busy, 1);
        repeat (7) step();

        // Frame D in the cycle right after done
        start_frame(ramp(0, 3));
        chk("overrun_sticky", overrun, 1);
        repeat (12) step();

        // Frame E aborted by reset in cycle 6
        start_frame(ramp(200, 7));
        repeat (5) step();
        resetN = 1'b0;
        exp_q.delete();
        addr_q.delete();
        cur_sin = ID_SIN;
        cur_cos = ID_COS;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_overrun", overrun, 0);
        chk("midrst_addr", trig_addr, 0);
        chk("midrst_sin", sin_val, ID_SIN);
        chk("midrst_cos", cos_val, ID_COS);
        repeat (3) step();
        resetN = 1'b1;
        step();

        // Frame F after reset
        start_frame(ramp(8'hA0, 1));
        repeat (12) step();

        // Edge instance: one sprite, latency 1
        c0 = cyc;
        angle1 = 8'hFF;
        frame_start1 = 1'b1;
        e1.cyc = c0 + 4;
        e1.s = 18'h0FF00;
        e1.c = 18'h300FF;
        exp1_q.push_back(e1);
        step();
        frame_start1 = 1'b0;
        chk("edge_addr", trig_addr1, 8'hFF);
        chk("edge_busy", busy1, 1);
        repeat (4) step();
        angle1 = 8'h01;
        frame_start1 = 1'b1;
        e1.cyc = c0 + 9;
        e1.s = 18'h00100;
        e1.c = 18'h3FEFF;
        exp1_q.push_back(e1);
        step();
        frame_start1 = 1'b0;
        chk("edge_b2b_busy", busy1, 1);
        chk("edge_b2b_addr", trig_addr1, 8'h01);
        repeat (5) step();
        chk("edge_overrun", overrun1, 0);

        for (int i = 0; i < 60 && (exp_q.size() != 0 || exp1_q.size() != 0 || addr_q.size() != 0); i++)
            step();
        if (exp_q.size() != 0 || exp1_q.size() != 0 || addr_q.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL timeout: got %0d pending expectations expected 0",
                     exp_q.size() + exp1_q.size() + addr_q.size());
        end
        step();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sprite_trig_scheduler.md
Name: sprite_trig_scheduler

Overview:
- Shares one sin/cos lookup ROM among NUM_SPRITES rotating-sprite drawers.
- Once per frame, on frame_start (start of vertical blank), it snapshots every sprite's angle and issues one ROM lookup per sprite, pipelined.
- Results are collected into shadow registers, then committed atomically to the per-sprite sin_val/cos_val outputs. Displayed sprites therefore never see a partially updated rotation set.
- Sits between the game-logic angle registers and the per-sprite drawers' sin_val/cos_val inputs.

Parameters:
- NUM_SPRITES, 8: number of sprites served (minimum 1).
- ANGLE_W, 8: angle width; 2^ANGLE_W steps per full turn; also the ROM address width.
- ROM_LATENCY, 2: clock cycles from trig_addr to valid trig_sin/trig_cos (minimum 1).
- TRIG_W, 18: signed sin/cos width, fixed-point format Q1.16.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- angle  in  NUM_SPRITES*ANGLE_W  packed angles, sprite k at bits [k*ANGLE_W +: ANGLE_W].
- trig_addr  out  ANGLE_W  ROM address.
- trig_sin  in  TRIG_W  signed ROM sin data.
- trig_cos  in  TRIG_W  signed ROM cos data.
- sin_val  out  NUM_SPRITES*TRIG_W  packed signed sin, same packing as angle.
- cos_val  out  NUM_SPRITES*TRIG_W  packed signed cos, same packing as angle.
- busy  out  1  high from the cycle after frame_start is accepted through the commit cycle.
- done  out  1  one-cycle pulse, coincident with the commit.
- overrun  out  1  sticky flag: frame_start arrived while busy.

Behaviour:
- Reset (asynchronous, any time, including mid-run):
  - FSM goes to IDLE; in-flight lookups are discarded.
  - Every sin_val slice = 0, every cos_val slice = TRIG_ONE (18'sh10000), i.e. identity rotation.
  - Shadow registers reset to the same identity values.
  - trig_addr = 0; busy = 0; done = 0; overrun = 0.
- FSM states: IDLE, ISSUE, DRAIN, COMMIT.
- IDLE:
  - On frame_start=1: snapshot the whole angle bus, clear issue index, go to ISSUE.
  - trig_addr holds its last value while idle.
- ISSUE:
  - Drives trig_addr = snapshot[idx] for one cycle per sprite, idx = 0..NUM_SPRITES-1.
  - idx enters a ROM_LATENCY-deep valid/index delay line.
  - After idx = NUM_SPRITES-1, go to DRAIN.
- Capture: when the delay-line output is valid, trig_sin/trig_cos are written to shadow[delayed idx]. The ROM is fully pipelined (one address per cycle).
- DRAIN: waits until the delay line is empty, then goes to COMMIT.
- COMMIT: copies all shadow slices to sin_val/cos_val, pulses done, returns to IDLE.
- Timing (cycle 0 = the cycle in which frame_start is high):
  - trig_addr for sprite k is valid in cycle k+1.
  - ROM data for sprite k is sampled at the end of cycle k+1+ROM_LATENCY.
  - done = 1 and outputs change in cycle NUM_SPRITES+ROM_LATENCY+2. With defaults: cycle 12.
- busy = 1 in cycles 1..NUM_SPRITES+ROM_LATENCY+2 inclusive.
- Angle changes after cycle 0 do not affect the current run (snapshot).
- Outputs are stable between commits; they only change in the done cycle.
- frame_start while busy=1, including the COMMIT cycle:
  - Ignored; no restart.
  - overrun set to 1, held until reset.
- frame_start in the cycle after done (IDLE): accepted normally.
- Angle wrap: angles are modular. 0 and 2^ANGLE_W-1 are adjacent; no saturation; address = angle unchanged.
- Widths:
  - No arithmetic on trig data; it is stored bit-exact.
  - idx width = max(1, $clog2(NUM_SPRITES)).

Decomposition:
- Package sprite_pkg holds:
  - TRIG_W = 18
  - TRIG_ONE = 18'sh10000
  - typedef trig_t (signed [TRIG_W-1:0])
  - FSM state enum (IDLE, ISSUE, DRAIN, COMMIT)
- One sub-module, lookup_delay_line: parameterized DEPTH and payload width; shift register carrying {valid, idx}; async reset clears all valid bits.

Test Plan:
- Reset check: assert resetN=0 -> all sin_val slices = 0, all cos_val slices = 18'sh10000, busy = done = overrun = 0.
- Single frame, defaults, ROM model returns sin = {addr, 8'h0}, cos = ~sin, latency 2; angles k*16 for sprite k; pulse frame_start at cycle 0:
  - trig_addr = 0,16,...,112 in cycles 1..8.
  - done only in cycle 12.
  - sprite 3 sin_val = 18'h3000 (addr 48 = 8'h30, shifted left 8 bits); cos_val = its complement.
  - Outputs unchanged before cycle 12.
- Snapshot: change all angles to 8'hFF in cycle 2 -> committed values still correspond to the original angles.
- Overrun: second frame_start in cycle 5 -> overrun = 1 and done still occurs once, in cycle 12. A later frame_start after done runs normally with overrun still 1.
- Reset mid-run: drop resetN in cycle 6 -> outputs back to identity, busy = 0, no done. A subsequent frame completes correctly.
- Edge configuration NUM_SPRITES=1, ROM_LATENCY=1: angle 8'hFF -> trig_addr 8'hFF in cycle 1, done in cycle 4; back-to-back frame_start in cycle 5 accepted.
